// File: rtl/alu_exec.sv
// Execution-stage ALU: single-cycle ADD/SUB/AND/OR and an iterative
// unsigned shift-add MUL, with registered results, flags and done pulse.
module alu_exec #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ctrl_command,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow
);

    localparam int unsigned ACC_W = 2 * WIDTH;

    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;

    typedef enum logic {
        IDLE,
        MUL_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   mcand_q, mcand_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic [ACC_W-1:0]   acc_add;

    // Single-cycle datapath; unknown opcodes (and MUL, unused here) fall to ADD
    always_comb begin
        sum     = reg1 + reg2;
        diff    = reg1 - reg2;
        alu_res = sum;
        alu_ovf = (reg1[WIDTH-1] == reg2[WIDTH-1]) && (sum[WIDTH-1] != reg1[WIDTH-1]);
        case (ctrl_command)
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (reg1[WIDTH-1] != reg2[WIDTH-1]) && (diff[WIDTH-1] != reg1[WIDTH-1]);
            end
            OP_AND: begin
                alu_res = reg1 & reg2;
                alu_ovf = 1'b0;
            end
            OP_OR: begin
                alu_res = reg1 | reg2;
                alu_ovf = 1'b0;
            end
            default: ;
        endcase
    end

    assign acc_add = acc_q + (mplier_q[0] ? mcand_q : ACC_W'(0));

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    if (ctrl_command == OP_MUL) begin
                        mcand_d  = ACC_W'(reg1);
                        mplier_d = reg2;
                        acc_d    = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = MUL_RUN;
                    end else begin
                        result_d    = alu_res;
                        result_hi_d = '0;
                        zero_d      = (alu_res == '0);
                        ovf_d       = alu_ovf;
                        done_d      = 1'b1;
                    end
                end
            end
            MUL_RUN: begin
                acc_d    = acc_add;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // Final iteration publishes the accumulator including its own add
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    result_d    = acc_add[WIDTH-1:0];
                    result_hi_d = acc_add[ACC_W-1:WIDTH];
                    zero_d      = (acc_add[WIDTH-1:0] == '0);
                    ovf_d       = |acc_add[ACC_W-1:WIDTH];
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: stimulus pushes expected completions,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_exec;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  ctrl_command;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        zero;
    logic        overflow;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        o;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    alu_exec #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .ctrl_command (ctrl_command),
        .reg1         (reg1),
        .reg2         (reg2),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .result_hi    (result_hi),
        .zero         (zero),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completion monitor
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: result=%h result_hi=%h (no completion expected)",
                         result, result_hi);
            end else begin
                e = sb_q.pop_front();
                if (result !== e.res || result_hi !== e.hi || zero !== e.z || overflow !== e.o) begin
                    n_err++;
                    $display("FAIL completion: got res=%h hi=%h z=%0b o=%0b, want res=%h hi=%h z=%0b o=%0b",
                             result, result_hi, zero, overflow, e.res, e.hi, e.z, e.o);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] r, input logic [31:0] h,
                         input logic z, input logic o);
        exp_t e;
        @(negedge clk);
        start        = 1'b1;
        ctrl_command = op;
        reg1         = a;
        reg2         = b;
        if (push) begin
            e = '{res: r, hi: h, z: z, o: o};
            sb_q.push_back(e);
        end
    endtask

    task automatic drop_start();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int k = 0;
        while (sb_q.size() != 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got %0d pending completions, want 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n        = 1'b1;
        start        = 1'b0;
        ctrl_command = 4'd0;
        reg1         = '0;
        reg2         = '0;

        // Asynchronous reset with no clock edge
        #2 rst_n = 1'b0;
        #1;
        check("reset_ctrl", 64'({busy, done, zero, overflow}), 64'd0);
        check("reset_result", {result_hi, result}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(4'd0, 32'd5, 32'd7, 1, 32'd12, 32'd0, 1'b0, 1'b0);
        drop_start();
        check("add_done_latency", 64'(done), 64'd1);
        @(negedge clk);
        check("add_done_pulse", 64'(done), 64'd0);
        check("add_result_hold", 64'(result), 64'd12);

        // Mid-cycle reset clears held result immediately
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_held", {result_hi, result} | 64'({busy, done, zero, overflow}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(4'd1, 32'h8000_0000, 32'd1, 1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1);
        drop_start();
        issue(4'd1, 32'd9, 32'd9, 1, 32'd0, 32'd0, 1'b1, 1'b0);
        drop_start();
        issue(4'd0, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        drop_start();
        issue(4'd1, 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0);
        drop_start();

        // Back-to-back AND, OR, default opcode
        issue(4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000, 32'd0, 1'b0, 1'b0);
        issue(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hFFF0_FFF0, 32'd0, 1'b0, 1'b0);
        check("b2b_done0", 64'(done), 64'd1);
        issue(4'd9, 32'd3, 32'd4, 1, 32'd7, 32'd0, 1'b0, 1'b0);
        check("b2b_done1", 64'(done), 64'd1);
        drop_start();
        check("b2b_done2", 64'(done), 64'd1);
        @(negedge clk);
        check("b2b_done_end", 64'(done), 64'd0);
        wait_drain("single", 5);

        // MUL timing window and full-width product
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b1);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            check($sformatf("mul_busy_c%0d", k), 64'(busy), 64'(k <= 32));
            check($sformatf("mul_done_c%0d", k), 64'(done), 64'(k == 33));
        end
        wait_drain("mul_max", 5);

        issue(4'd2, 32'd1000, 32'd3000, 1, 32'd3000000, 32'd0, 1'b0, 1'b0);
        drop_start();
        wait_drain("mul_small", 40);

        // Start and operand changes while busy are ignored
        issue(4'd2, 32'd6, 32'd7, 1, 32'd42, 32'd0, 1'b0, 1'b0);
        drop_start();
        @(negedge clk);
        @(negedge clk);
        start        = 1'b1;
        ctrl_command = 4'd0;
        reg1         = 32'd100;
        reg2         = 32'd200;
        @(negedge clk);
        start = 1'b0;
        reg1  = 32'd1;
        reg2  = 32'd1;
        wait_drain("mul_busy_guard", 40);
        repeat (5) @(negedge clk);
        check("guard_result", 64'(result), 64'd42);

        // Reset during MUL aborts with no completion
        issue(4'd2, 32'h1234_5678, 32'd9, 0, '0, '0, 1'b0, 1'b0);
        drop_start();
        repeat (9) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cleared", {result_hi, result} | 64'({busy, done, zero, overflow}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_busy", 64'(busy), 64'd0);

        issue(4'd2, 32'd2, 32'd3, 1, 32'd6, 32'd0, 1'b0, 1'b0);
        drop_start();
        wait_drain("mul_after_abort", 40);
        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
